// File: rtl/galaksija_tap_saver_if.sv
`default_nettype none
// ============================================================================
// Module   : galaksija_tap_saver_if
// Brief    : hps_io upload handshake between the HPS and the cassette saver.
// Revision : 1.0  initial release
// ============================================================================
interface galaksija_tap_saver_if;
  logic        ioctl_upload_req;
  logic [7:0]  ioctl_upload_index;
  logic        ioctl_upload;
  logic        ioctl_rd;
  logic [26:0] ioctl_addr;
  logic [7:0]  ioctl_din;

  // master = HPS side, slave = saver side
  modport master (
    input  ioctl_upload_req, ioctl_upload_index, ioctl_din,
    output ioctl_upload, ioctl_rd, ioctl_addr
  );

  modport slave (
    output ioctl_upload_req, ioctl_upload_index, ioctl_din,
    input  ioctl_upload, ioctl_rd, ioctl_addr
  );
endinterface
`default_nettype wire

// File: rtl/galaksija_tap_saver.sv
`default_nettype none
// ============================================================================
// Module   : galaksija_tap_saver
// Brief    : Dumps a RAM range to the HPS as a TAP file (header, data, checksum).
// Revision : 1.0  initial release
// ============================================================================
module galaksija_tap_saver #(
  parameter int         AW         = 16,
  parameter logic [7:0] UPLOAD_IDX = 8'h01
) (
  input  wire logic              clk_sys,
  input  wire logic              reset_in,
  input  wire logic              save_start,
  input  wire logic [AW-1:0]     save_from,
  input  wire logic [AW-1:0]     save_to,
  output logic                   busy,
  output logic                   cpu_wait,
  output logic                   error,
  output logic [AW-1:0]          ram_addr,
  output logic                   ram_rd,
  input  wire logic [7:0]        ram_dout,
  galaksija_tap_saver_if.slave   hps,
  output logic [16:0]            file_len
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_CALC    = 3'd1,
    S_REQ     = 3'd2,
    S_WAIT_UP = 3'd3,
    S_SERVE   = 3'd4,
    S_FETCH   = 3'd5,
    S_DONE    = 3'd6
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [AW-1:0] r_from;
  logic [AW-1:0] r_to;
  logic [AW-1:0] r_rd_ptr;
  logic          r_issue_done;
  logic          r_dv;
  logic          r_dv_last;
  logic          r_fin;
  logic          r_error;
  logic [7:0]    r_sum;
  logic [7:0]    r_chk;
  logic [7:0]    r_din;
  logic [16:0]   r_len;
  logic          w_upload_req;
  logic          w_start_ok;
  logic          w_is_hdr;
  logic          w_is_data;
  logic          w_is_chk;
  logic [26:0]   w_chk_off;
  logic [15:0]   w_from16;
  logic [15:0]   w_to16;
  logic [AW-1:0] w_fetch_addr;

  assign w_start_ok   = save_start && (save_to >= save_from);
  assign w_chk_off    = 27'(r_len) - 27'd1;
  assign w_is_hdr     = hps.ioctl_addr < 27'd4;
  assign w_is_data    = !w_is_hdr && (hps.ioctl_addr < w_chk_off);
  assign w_is_chk     = hps.ioctl_addr == w_chk_off;
  assign w_fetch_addr = r_from + AW'(hps.ioctl_addr - 27'd4);
  assign w_from16     = 16'(r_from);
  assign w_to16       = 16'(r_to);

  assign hps.ioctl_upload_req   = w_upload_req;
  assign hps.ioctl_upload_index = UPLOAD_IDX;
  assign hps.ioctl_din          = r_din;
  assign error                  = r_error;
  assign file_len               = r_len;

  always_ff @(posedge clk_sys or negedge reset_in) begin
    if (!reset_in) r_state <= S_IDLE;
    else           r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt  = r_state;
    busy         = 1'b1;
    cpu_wait     = 1'b0;
    w_upload_req = 1'b0;
    ram_rd       = 1'b0;
    ram_addr     = '0;
    case (r_state)
      S_IDLE: begin
        busy = 1'b0;
        if (w_start_ok) w_state_nxt = S_CALC;
      end
      S_CALC: begin
        cpu_wait = 1'b1;
        if (!r_issue_done) begin
          ram_rd   = 1'b1;
          ram_addr = r_rd_ptr;
        end
        if (r_fin) w_state_nxt = S_REQ;
      end
      S_REQ: begin
        cpu_wait     = 1'b1;
        w_upload_req = 1'b1;
        w_state_nxt  = S_WAIT_UP;
      end
      S_WAIT_UP: begin
        cpu_wait = 1'b1;
        if (hps.ioctl_upload) w_state_nxt = S_SERVE;
      end
      S_SERVE: begin
        cpu_wait = 1'b1;
        if (!hps.ioctl_upload) begin
          w_state_nxt = S_DONE;
        end else if (hps.ioctl_rd && w_is_data) begin
          ram_rd      = 1'b1;
          ram_addr    = w_fetch_addr;
          w_state_nxt = S_FETCH;
        end
      end
      S_FETCH: begin
        // The outstanding byte is always delivered, even if the upload just closed
        cpu_wait    = 1'b1;
        w_state_nxt = hps.ioctl_upload ? S_SERVE : S_DONE;
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        busy        = 1'b0;
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_sys or negedge reset_in) begin
    if (!reset_in) begin
      r_from       <= '0;
      r_to         <= '0;
      r_rd_ptr     <= '0;
      r_issue_done <= 1'b0;
      r_dv         <= 1'b0;
      r_dv_last    <= 1'b0;
      r_fin        <= 1'b0;
      r_error      <= 1'b0;
      r_sum        <= 8'h00;
      r_chk        <= 8'h00;
      r_din        <= 8'h00;
      r_len        <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (save_start) begin
            r_error <= (save_to < save_from);
            if (w_start_ok) begin
              r_from       <= save_from;
              r_to         <= save_to;
              r_rd_ptr     <= save_from;
              r_issue_done <= 1'b0;
              r_dv         <= 1'b0;
              r_dv_last    <= 1'b0;
              r_fin        <= 1'b0;
              r_sum        <= 8'h00;
              r_chk        <= 8'h00;
              r_len        <= 17'(save_to - save_from) + 17'd6;
            end
          end
        end
        S_CALC: begin
          // Read at cycle k, accumulate at k+1, finalise checksum one cycle later
          r_dv      <= ram_rd;
          r_dv_last <= ram_rd && (r_rd_ptr == r_to);
          if (ram_rd) begin
            r_rd_ptr <= r_rd_ptr + AW'(1);
            if (r_rd_ptr == r_to) r_issue_done <= 1'b1;
          end
          if (r_dv) begin
            r_sum <= r_sum + ram_dout;
            if (r_dv_last) r_fin <= 1'b1;
          end
          if (r_fin) r_chk <= 8'hFF - r_sum;
        end
        S_SERVE: begin
          if (hps.ioctl_upload && hps.ioctl_rd) begin
            if (w_is_hdr) begin
              case (hps.ioctl_addr[1:0])
                2'd0:    r_din <= w_from16[7:0];
                2'd1:    r_din <= w_from16[15:8];
                2'd2:    r_din <= w_to16[7:0];
                default: r_din <= w_to16[15:8];
              endcase
            end else if (w_is_chk) begin
              r_din <= r_chk;
            end else if (!w_is_data) begin
              r_din <= 8'h00;
            end
          end
        end
        S_FETCH: begin
          r_din <= ram_dout;
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_galaksija_tap_saver.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_galaksija_tap_saver
// Brief    : Randomised scoreboard bench for the cassette TAP saver.
// Revision : 1.0  initial release
// ============================================================================
module tb_galaksija_tap_saver;

  logic        clk_sys = 1'b0;
  logic        reset_in;
  logic        save_start;
  logic [15:0] save_from;
  logic [15:0] save_to;
  logic        busy;
  logic        cpu_wait;
  logic        error;
  logic [15:0] ram_addr;
  logic        ram_rd;
  logic [7:0]  ram_dout = 8'h00;
  logic [16:0] file_len;

  galaksija_tap_saver_if hps();

  galaksija_tap_saver #(.AW(16), .UPLOAD_IDX(8'h01)) dut (
    .clk_sys    (clk_sys),
    .reset_in   (reset_in),
    .save_start (save_start),
    .save_from  (save_from),
    .save_to    (save_to),
    .busy       (busy),
    .cpu_wait   (cpu_wait),
    .error      (error),
    .ram_addr   (ram_addr),
    .ram_rd     (ram_rd),
    .ram_dout   (ram_dout),
    .hps        (hps.slave),
    .file_len   (file_len)
  );

  always #5 clk_sys = ~clk_sys;

  // Machine RAM: data valid the cycle after the strobe
  logic [7:0] mem [0:65535];
  always @(posedge clk_sys) if (ram_rd) ram_dout <= mem[ram_addr];

  int req_cnt = 0;
  int rd_cnt  = 0;
  always @(posedge clk_sys) begin
    if (hps.ioctl_upload_req) req_cnt <= req_cnt + 1;
    if (ram_rd)               rd_cnt  <= rd_cnt + 1;
  end

  int vectors = 0;
  int errors  = 0;

  typedef struct {
    logic [7:0] val;
    int         lat;
    int         off;
  } exp_t;
  exp_t       exp_q[$];
  logic [7:0] file_q[$];
  int         rd_list[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Expected file straight from the format: header, data bytes, 0xFF - sum
  task automatic build_file(input logic [15:0] f, input logic [15:0] t);
    int s;
    s = 0;
    file_q.delete();
    file_q.push_back(f[7:0]);
    file_q.push_back(f[15:8]);
    file_q.push_back(t[7:0]);
    file_q.push_back(t[15:8]);
    for (int a = int'(f); a <= int'(t); a++) begin
      file_q.push_back(mem[a]);
      s += int'(mem[a]);
    end
    file_q.push_back(8'(255 - (s % 256)));
  endtask

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic pulse_start(input logic [15:0] f, input logic [15:0] t);
    save_from  = f;
    save_to    = t;
    save_start = 1'b1;
    tick();
    save_start = 1'b0;
  endtask

  task automatic hps_read(input int off);
    exp_t e;
    e.off = off;
    e.val = (off < file_q.size()) ? file_q[off] : 8'h00;
    e.lat = (off >= 4 && off < file_q.size() - 1) ? 2 : 1;
    exp_q.push_back(e);
    hps.ioctl_rd   = 1'b1;
    hps.ioctl_addr = 27'(off);
    tick();
    hps.ioctl_rd = 1'b0;
    repeat (3) tick();
  endtask

  task automatic run_save(input logic [15:0] f, input logic [15:0] t, input bit start_in_serve);
    int n;
    int k;
    int req0;
    int rd0;
    n    = int'(t) - int'(f) + 1;
    req0 = req_cnt;
    rd0  = rd_cnt;
    build_file(f, t);
    tick();
    pulse_start(f, t);
    check("error_cleared", 32'(error), 32'd0);
    check("busy_calc", 32'(busy), 32'd1);
    check("cpu_wait_calc", 32'(cpu_wait), 32'd1);
    k = 0;
    while (!hps.ioctl_upload_req && k < 300) begin
      @(negedge clk_sys);
      k++;
    end
    check("calc_cycles_to_req", 32'(k), 32'(n + 3));
    if (k >= 300) return;
    check("calc_ram_reads", 32'(rd_cnt - rd0), 32'(n));
    check("file_len", 32'(file_len), 32'(n + 5));
    check("upload_index", 32'(hps.ioctl_upload_index), 32'h01);
    tick();
    hps.ioctl_upload = 1'b1;
    repeat (2) tick();
    foreach (rd_list[i]) begin
      hps_read(rd_list[i]);
      if (start_in_serve && i == 1) begin
        pulse_start(16'h0100, 16'h01FF);
        check("start_in_serve_len", 32'(file_len), 32'(n + 5));
        check("start_in_serve_busy", 32'(busy), 32'd1);
      end
    end
    k = 0;
    while (exp_q.size() != 0 && k < 50) begin
      tick();
      k++;
    end
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    hps.ioctl_upload = 1'b0;
    @(negedge clk_sys);
    check("busy_serve_after_fall", 32'(busy), 32'd1);
    @(negedge clk_sys);
    check("busy_done", 32'(busy), 32'd1);
    check("cpu_wait_done", 32'(cpu_wait), 32'd0);
    @(negedge clk_sys);
    check("busy_idle", 32'(busy), 32'd0);
    check("req_pulses", 32'(req_cnt - req0), 32'd1);
  endtask

  // Scoreboard monitor: each byte request is matched against the queued expectation
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk_sys);
      if (hps.ioctl_rd === 1'b1) begin
        if (exp_q.size() == 0) begin
          check("unexpected_rd", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          repeat (e.lat) @(negedge clk_sys);
          check($sformatf("ioctl_din_off%0d", e.off), 32'(hps.ioctl_din), 32'(e.val));
        end
      end
    end
  end

  initial begin : stim
    int f;
    int n;
    int req0;
    reset_in         = 1'b0;
    save_start       = 1'b0;
    save_from        = '0;
    save_to          = '0;
    hps.ioctl_upload = 1'b0;
    hps.ioctl_rd     = 1'b0;
    hps.ioctl_addr   = '0;
    for (int a = 0; a < 65536; a++) mem[a] = 8'($urandom);
    repeat (2) tick();
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_cpu_wait", 32'(cpu_wait), 32'd0);
    check("rst_error", 32'(error), 32'd0);
    check("rst_req", 32'(hps.ioctl_upload_req), 32'd0);
    check("rst_file_len", 32'(file_len), 32'd0);
    check("rst_din", 32'(hps.ioctl_din), 32'd0);
    reset_in = 1'b1;
    tick();

    // Directed: three-byte save, full read then out-of-order offsets
    mem[16'h2C3A] = 8'h01;
    mem[16'h2C3B] = 8'h02;
    mem[16'h2C3C] = 8'h03;
    rd_list = '{0, 1, 2, 3, 4, 5, 6, 7, 6, 0, 6, 9};
    run_save(16'h2C3A, 16'h2C3C, 1'b0);
    check("t1_chk_byte", 32'(file_q[7]), 32'hF9);

    // Single byte 0xFF gives checksum 0
    mem[16'h3000] = 8'hFF;
    rd_list = '{5, 4, 0, 3, 6};
    run_save(16'h3000, 16'h3000, 1'b0);

    // Reversed range flags error without starting
    tick();
    req0 = req_cnt;
    pulse_start(16'h3000, 16'h2FFF);
    check("err_set", 32'(error), 32'd1);
    check("err_busy", 32'(busy), 32'd0);
    repeat (5) tick();
    check("err_no_req", 32'(req_cnt - req0), 32'd0);
    rd_list = '{0, 4, 5, 6};
    run_save(16'h1234, 16'h1235, 1'b0);

    // Reset mid-CALC
    tick();
    req0 = req_cnt;
    pulse_start(16'h1000, 16'h1009);
    repeat (2) tick();
    reset_in = 1'b0;
    #1;
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_cpu_wait", 32'(cpu_wait), 32'd0);
    check("mid_rst_ram_rd", 32'(ram_rd), 32'd0);
    check("mid_rst_ram_addr", 32'(ram_addr), 32'd0);
    check("mid_rst_file_len", 32'(file_len), 32'd0);
    check("mid_rst_din", 32'(hps.ioctl_din), 32'd0);
    repeat (2) tick();
    reset_in = 1'b1;
    repeat (20) tick();
    check("mid_rst_no_req", 32'(req_cnt - req0), 32'd0);
    check("mid_rst_idle", 32'(busy), 32'd0);
    rd_list = '{0, 1, 2, 3, 4, 13, 14, 15};
    run_save(16'h1000, 16'h1009, 1'b0);

    // save_start while serving is ignored
    rd_list = '{4, 2, 5, 7, 8};
    run_save(16'h4000, 16'h4003, 1'b1);

    // Randomised ranges and offsets
    for (int it = 0; it < 8; it++) begin
      n = int'($urandom_range(1, 24));
      f = int'($urandom_range(0, 65535 - n));
      rd_list.delete();
      for (int r = 0; r < 8; r++) rd_list.push_back(int'($urandom_range(0, n + 8)));
      run_save(16'(f), 16'(f + n - 1), 1'b0);
    end

    repeat (4) tick();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
`default_nettype wire
